// File: rtl/data_memory_pkg.sv
// Shared constants, region type and address decoder for the data-memory subsystem.
package data_memory_pkg;

    localparam int IO_SWITCHES    = 0;
    localparam int IO_GPIO_IN_LO  = 1;
    localparam int IO_GPIO_IN_HI  = 2;
    localparam int IO_GPIO_OUT_LO = 3;
    localparam int IO_GPIO_OUT_HI = 4;

    typedef enum logic [1:0] {
        REG_IO,
        REG_RAM,
        REG_OOR
    } region_e;

    // Widened to 64 bits so io_words + mem_depth can never wrap for any ADDR_W.
    function automatic region_e decode_region(
        input logic [63:0] addr,
        input logic [63:0] io_words,
        input logic [63:0] mem_depth
    );
        if (addr < io_words) begin
            return REG_IO;
        end
        if (addr < io_words + mem_depth) begin
            return REG_RAM;
        end
        return REG_OOR;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_dp_ram.sv
// Inferred dual-port RAM: port A read/write, port B read-only, read-before-write,
// one-cycle registered read data held while its port is idle.
module dp_ram #(
    parameter int MEM_W     = 16,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_we,
    input  logic                         a_re,
    input  logic [$clog2(MEM_DEPTH)-1:0] a_addr,
    input  logic [MEM_W-1:0]             a_wdata,
    output logic [MEM_W-1:0]             a_rdata,
    input  logic                         b_re,
    input  logic [$clog2(MEM_DEPTH)-1:0] b_addr,
    output logic [MEM_W-1:0]             b_rdata
);

    logic [MEM_W-1:0] r_mem [MEM_DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; resetting
    // it would force thousands of flops.
    always_ff @(posedge clk) begin
        if (a_we) begin
            r_mem[a_addr] <= a_wdata;
        end
    end

    // NOTE: non-blocking reads of r_mem see the pre-edge contents, which is what
    // gives port B old data on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_re) begin
                a_rdata <= r_mem[a_addr];
            end
            if (b_re) begin
                b_rdata <= r_mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Load/store data memory: IO window plus main RAM on port A, RAM-only read port B,
// synchronised board inputs and registered GPIO outputs.
module data_memory_ctrl #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 24,
    parameter int MEM_W     = 16,
    parameter int MEM_DEPTH = 4096,
    parameter int IO_WORDS  = 76,
    parameter int SW_W      = 4,
    parameter int GPIO_W    = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_rvalid,
    output logic [MEM_W-1:0]  b_rdata,
    output logic              b_err,
    input  logic [SW_W-1:0]   switches,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out
);

    import data_memory_pkg::*;

    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int GPIO_HI_W = GPIO_W - DATA_W;

    region_e           w_a_region;
    region_e           w_b_region;
    logic [IDX_W-1:0]  w_a_idx;
    logic [IDX_W-1:0]  w_b_idx;
    logic              w_a_rd;
    logic              w_a_wr;
    logic              w_ram_a_we;
    logic              w_ram_a_re;
    logic              w_ram_b_re;
    logic [MEM_W-1:0]  w_ram_a_q;
    logic [MEM_W-1:0]  w_ram_b_q;
    logic [DATA_W-1:0] w_io_rdata;

    logic [SW_W-1:0]   r_sw_meta;
    logic [SW_W-1:0]   r_sw_sync;
    logic [GPIO_W-1:0] r_gpio_meta;
    logic [GPIO_W-1:0] r_gpio_sync;
    logic [GPIO_W-1:0] r_gpio_out;
    logic              r_a_rvalid;
    logic              r_a_err;
    region_e           r_a_sel;
    logic [DATA_W-1:0] r_a_io;
    logic              r_b_rvalid;
    logic              r_b_err;
    logic              r_b_ok;

    assign w_a_region = decode_region(64'(a_addr), 64'(IO_WORDS), 64'(MEM_DEPTH));
    assign w_b_region = decode_region(64'(b_addr), 64'(IO_WORDS), 64'(MEM_DEPTH));
    assign w_a_idx    = IDX_W'(a_addr - ADDR_W'(IO_WORDS));
    assign w_b_idx    = IDX_W'(b_addr - ADDR_W'(IO_WORDS));

    assign w_a_rd     = a_req & ~a_we;
    assign w_a_wr     = a_req & a_we;
    assign w_ram_a_we = w_a_wr & (w_a_region == REG_RAM) & ~rst;
    assign w_ram_a_re = w_a_rd & (w_a_region == REG_RAM);
    assign w_ram_b_re = b_req & (w_b_region == REG_RAM);

    dp_ram #(
        .MEM_W     (MEM_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_we    (w_ram_a_we),
        .a_re    (w_ram_a_re),
        .a_addr  (w_a_idx),
        .a_wdata (a_wdata[MEM_W-1:0]),
        .a_rdata (w_ram_a_q),
        .b_re    (w_ram_b_re),
        .b_addr  (w_b_idx),
        .b_rdata (w_ram_b_q)
    );

    // NOTE: defaulting w_io_rdata before the case keeps unmapped IO addresses
    // from inferring a latch.
    always_comb begin
        w_io_rdata = '0;
        case (a_addr)
            ADDR_W'(IO_SWITCHES):    w_io_rdata = DATA_W'(r_sw_sync);
            ADDR_W'(IO_GPIO_IN_LO):  w_io_rdata = r_gpio_sync[DATA_W-1:0];
            ADDR_W'(IO_GPIO_IN_HI):  w_io_rdata = DATA_W'(r_gpio_sync[GPIO_W-1:DATA_W]);
            ADDR_W'(IO_GPIO_OUT_LO): w_io_rdata = r_gpio_out[DATA_W-1:0];
            ADDR_W'(IO_GPIO_OUT_HI): w_io_rdata = DATA_W'(r_gpio_out[GPIO_W-1:DATA_W]);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta   <= '0;
            r_sw_sync   <= '0;
            r_gpio_meta <= '0;
            r_gpio_sync <= '0;
            r_gpio_out  <= '0;
            r_a_rvalid  <= 1'b0;
            r_a_err     <= 1'b0;
            r_a_sel     <= REG_OOR;
            r_a_io      <= '0;
            r_b_rvalid  <= 1'b0;
            r_b_err     <= 1'b0;
            r_b_ok      <= 1'b0;
        end else begin
            r_sw_meta   <= switches;
            r_sw_sync   <= r_sw_meta;
            r_gpio_meta <= gpio_in;
            r_gpio_sync <= r_gpio_meta;

            r_a_rvalid <= w_a_rd;
            r_a_err    <= a_req & (w_a_region == REG_OOR);
            // Read data source is only re-selected by a read, so writes and idle cycles hold it.
            if (w_a_rd) begin
                r_a_sel <= w_a_region;
                r_a_io  <= w_io_rdata;
            end

            if (w_a_wr && (w_a_region == REG_IO)) begin
                if (a_addr == ADDR_W'(IO_GPIO_OUT_LO)) begin
                    r_gpio_out[DATA_W-1:0] <= a_wdata;
                end else if (a_addr == ADDR_W'(IO_GPIO_OUT_HI)) begin
                    r_gpio_out[GPIO_W-1:DATA_W] <= a_wdata[GPIO_HI_W-1:0];
                end
            end

            r_b_rvalid <= b_req;
            r_b_err    <= b_req & (w_b_region != REG_RAM);
            if (b_req) begin
                r_b_ok <= (w_b_region == REG_RAM);
            end
        end
    end

    always_comb begin
        case (r_a_sel)
            REG_IO:  a_rdata = r_a_io;
            REG_RAM: a_rdata = {{(DATA_W - MEM_W){w_ram_a_q[MEM_W-1]}}, w_ram_a_q};
            default: a_rdata = '0;
        endcase
    end

    assign a_rvalid = r_a_rvalid;
    assign a_err    = r_a_err;
    assign b_rvalid = r_b_rvalid;
    assign b_err    = r_b_err;
    assign b_rdata  = r_b_ok ? w_ram_b_q : '0;
    assign gpio_out = r_gpio_out;

endmodule
